// File: rtl/divu_queue.sv
// Request FIFO in front of an external unsigned divider. Requests are issued one at
// a time, and each result is held until the consumer takes it.
module divu_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic [WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0] div_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_div_start;
  logic             r_out_valid;
  logic             r_out_dbz;
  logic [WIDTH-1:0] r_out_quo;
  logic [WIDTH-1:0] r_out_rem;

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;

  // A full FIFO accepts nothing, even when the head is being popped this cycle.
  assign in_ready = (r_count < FULL_COUNT);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_ISSUE);

  // NOTE: the payload array has no reset; stale entries are never observed because
  // the pointers and count are reset, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= in_a;
      r_mem_b[r_wptr] <= in_b;
    end
  end

  // NOTE: every register is updated with non-blocking assignments so all blocks
  // see the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // ISSUE is only entered with a non-empty FIFO, so its pop can never underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_quo   <= '0;
      r_out_rem   <= '0;
      r_out_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) && !div_busy) begin
            r_state     <= S_ISSUE;
            r_div_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_div_start <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            r_out_quo   <= div_val;
            r_out_rem   <= div_rem;
            r_out_dbz   <= div_dbz;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_div_start <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign div_start = r_div_start;
  assign div_a     = r_mem_a[r_rptr];
  assign div_b     = r_mem_b[r_rptr];
  assign out_valid = r_out_valid;
  assign out_quo   = r_out_quo;
  assign out_rem   = r_out_rem;
  assign out_dbz   = r_out_dbz;

endmodule

// File: tb/tb_divu_queue.sv
// Bench for divu_queue: a behavioural divider drives the DUT, and a request-order
// scoreboard checks issue operands, FIFO occupancy and every delivered result.
module tb_divu_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_busy = 1'b0;
  logic             div_done = 1'b0;
  logic             div_dbz = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic [WIDTH-1:0] div_rem = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_quo;
  logic [WIDTH-1:0] out_rem;
  logic             out_dbz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divu_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_dbz(div_dbz),
    .div_val(div_val), .div_rem(div_rem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quo(out_quo), .out_rem(out_rem), .out_dbz(out_dbz)
  );

  // Expected {dbz, quotient, remainder}; the divider reports all-ones / dividend on b == 0.
  function automatic logic [2*WIDTH:0] ref_div(input req_t r);
    if (r.b == '0) return {1'b1, {WIDTH{1'b1}}, r.a};
    return {1'b0, WIDTH'(r.a / r.b), WIDTH'(r.a % r.b)};
  endfunction

  // ---------------- divider model: reacts at 2 time units after each edge ----------
  int               lat_fixed   = 0;
  bit               inject_done = 1'b0;
  logic [WIDTH-1:0] inj_val, inj_rem;
  logic             inj_dbz;
  int               mcnt   = 0;
  int               n_mdone = 0;
  logic [WIDTH-1:0] ma, mb;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      div_done = 1'b0;
      if (inject_done) begin
        div_done    = 1'b1;
        div_val     = inj_val;
        div_rem     = inj_rem;
        div_dbz     = inj_dbz;
        inject_done = 1'b0;
      end
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          div_done = 1'b1;
          div_busy = 1'b0;
          n_mdone++;
          if (mb == '0) begin
            div_dbz = 1'b1; div_val = '1; div_rem = ma;
          end else begin
            div_dbz = 1'b0; div_val = ma / mb; div_rem = ma % mb;
          end
        end
      end
      if (div_start && !rst) begin
        n_vec++;
        if (div_busy !== 1'b0) begin
          n_err++;
          $display("FAIL start_while_busy: div_busy=%b at div_start, want 0", div_busy);
        end
        ma       = div_a;
        mb       = div_b;
        div_busy = 1'b1;
        mcnt     = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      end
    end
  end

  // ---------------- scoreboard monitor: samples 3 time units after each edge -------
  req_t             iss_q[$];
  req_t             res_q[$];
  bit               mon_en     = 1'b0;
  bit               prev_start = 1'b0;
  bit               hold_prev  = 1'b0;
  int               n_starts   = 0;
  logic [2*WIDTH:0] held;

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mon_en) begin
        n_vec++;
        if (in_ready !== (iss_q.size() < DEPTH)) begin
          n_err++;
          $display("FAIL in_ready: got %b want %b (occupancy %0d)", in_ready,
                   (iss_q.size() < DEPTH), iss_q.size());
        end
        if (hold_prev) begin
          n_vec++;
          if (out_valid !== 1'b1 || {out_dbz, out_quo, out_rem} !== held) begin
            n_err++;
            $display("FAIL hold_stable: got v=%b %h want v=1 %h", out_valid,
                     {out_dbz, out_quo, out_rem}, held);
          end
        end
        if (div_start) begin
          n_starts++;
          n_vec++;
          if (prev_start || iss_q.size() == 0) begin
            n_err++;
            $display("FAIL start_pulse: got start (prev=%b, queued=%0d) want single pulse on non-empty",
                     prev_start, iss_q.size());
          end else begin
            if ({div_a, div_b} !== {iss_q[0].a, iss_q[0].b}) begin
              n_err++;
              $display("FAIL issue_operands: got %h/%h want %h/%h", div_a, div_b,
                       iss_q[0].a, iss_q[0].b);
            end
            res_q.push_back(iss_q.pop_front());
          end
        end
        prev_start = div_start;
        if (out_valid && out_ready) begin
          n_vec++;
          if (res_q.size() == 0) begin
            n_err++;
            $display("FAIL result_order: got unexpected result %h want none",
                     {out_dbz, out_quo, out_rem});
          end else begin
            req_t r;
            r = res_q.pop_front();
            if ({out_dbz, out_quo, out_rem} !== ref_div(r)) begin
              n_err++;
              $display("FAIL result: got %h want %h for %0d/%0d",
                       {out_dbz, out_quo, out_rem}, ref_div(r), r.a, r.b);
            end
          end
        end
        if (in_valid && in_ready) iss_q.push_back('{in_a, in_b});
        hold_prev = out_valid && !out_ready;
        held      = {out_dbz, out_quo, out_rem};
      end else begin
        prev_start = 1'b0;
        hold_prev  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (inputs change 1 time unit after edges) -------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL offer_timeout: got no in_ready in 60 cycles want accept");
    end
  endtask

  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (iss_q.size() == 0 && res_q.size() == 0 && !out_valid && !div_busy) ok = 1'b1;
      else step();
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d queued %0d in flight want 0/0",
               iss_q.size(), res_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_vec++;
    if ({div_start, out_valid, out_dbz, out_quo, out_rem, in_ready} !==
        {1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got st=%b v=%b dbz=%b q=%h r=%h rdy=%b want 0 0 0 00 00 1",
               div_start, out_valid, out_dbz, out_quo, out_rem, in_ready);
    end
    step();
    step();
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int s0 = n_starts;
    lat_fixed = 2;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd2;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (div_start !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got div_start=%b one cycle after push want 0", div_start);
    end
    step();
    n_vec++;
    if ({div_start, div_a, div_b} !== {1'b1, 8'd7, 8'd2}) begin
      n_err++;
      $display("FAIL latency_issue: got st=%b a=%0d b=%0d want 1 7 2", div_start, div_a, div_b);
    end
    wait_out(20, ok);
    n_vec++;
    if (!ok || {out_dbz, out_quo, out_rem} !== {1'b0, 8'd3, 8'd1}) begin
      n_err++;
      $display("FAIL basic_result: got ok=%b dbz=%b q=%0d r=%0d want 1 0 3 1",
               ok, out_dbz, out_quo, out_rem);
    end
    repeat (4) step();
    n_vec++;
    if (n_starts - s0 !== 1) begin
      n_err++;
      $display("FAIL basic_start_count: got %0d want 1", n_starts - s0);
    end
    lat_fixed = 0;
  endtask

  task automatic test_dbz();
    bit ok;
    out_ready = 1'b1;
    offer(8'd9, 8'd0);
    offer(8'd20, 8'd3);
    wait_out(30, ok);
    n_vec++;
    if (!ok || {out_dbz, out_quo, out_rem} !== {1'b1, 8'hFF, 8'd9}) begin
      n_err++;
      $display("FAIL dbz_result: got ok=%b dbz=%b q=%h r=%h want 1 1 ff 09",
               ok, out_dbz, out_quo, out_rem);
    end
    step();
    wait_out(30, ok);
    n_vec++;
    if (!ok || {out_dbz, out_quo, out_rem} !== {1'b0, 8'd6, 8'd2}) begin
      n_err++;
      $display("FAIL after_dbz: got ok=%b dbz=%b q=%0d r=%0d want 1 0 6 2",
               ok, out_dbz, out_quo, out_rem);
    end
    drain();
  endtask

  task automatic test_hold();
    bit ok;
    logic [2*WIDTH:0] snap;
    out_ready = 1'b0;
    offer(8'd100, 8'd7);
    wait_out(30, ok);
    n_vec++;
    if (!ok || {out_dbz, out_quo, out_rem} !== {1'b0, 8'd14, 8'd2}) begin
      n_err++;
      $display("FAIL hold_result: got ok=%b dbz=%b q=%0d r=%0d want 1 0 14 2",
               ok, out_dbz, out_quo, out_rem);
    end
    snap = {out_dbz, out_quo, out_rem};
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 2);
      in_a = 8'($urandom);
      in_b = 8'($urandom_range(1, 255));
      step();
      n_vec++;
      if (out_valid !== 1'b1 || div_start !== 1'b0 || {out_dbz, out_quo, out_rem} !== snap) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got v=%b st=%b %h want v=1 st=0 %h",
                 i, out_valid, div_start, {out_dbz, out_quo, out_rem}, snap);
      end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    req_t ops[6];
    int   acc = 0;
    bit   ok = 1'b0;
    for (int i = 0; i < 6; i++) ops[i] = '{8'($urandom), 8'($urandom_range(1, 15))};
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = 1'b1; in_a = ops[acc].a; in_b = ops[acc].b;
      if (in_ready && acc < 5) acc++;
      else if (in_ready) acc = 99;
      step();
    end
    n_vec++;
    if (acc !== DEPTH + 1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_stall: got accepted=%0d in_ready=%b want %0d 0", acc, in_ready, DEPTH + 1);
    end
    out_ready = 1'b1;
    in_a = ops[5].a; in_b = ops[5].b;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL stalled_accept: got no accept want accept after pop");
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_a      = 8'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain();
  endtask

  task automatic test_spurious();
    logic [2*WIDTH:0] snap;
    int s0 = n_starts;
    snap = {out_dbz, out_quo, out_rem};
    inj_val = 8'hA5; inj_rem = 8'h5A; inj_dbz = 1'b1;
    inject_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0 || {out_dbz, out_quo, out_rem} !== snap || n_starts !== s0) begin
        n_err++;
        $display("FAIL spurious_done%0d: got v=%b %h starts+%0d want v=0 %h starts+0",
                 i, out_valid, {out_dbz, out_quo, out_rem}, n_starts - s0, snap);
      end
    end
  endtask

  task automatic test_reset_wait();
    bit ok = 1'b0;
    int d0;
    lat_fixed = 12;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) offer(8'(40 + i), 8'd3);
    for (int i = 0; i < 20 && !ok; i++) begin
      if (div_busy && !out_valid) ok = 1'b1;
      else step();
    end
    n_vec++;
    if (!ok || iss_q.size() !== 3) begin
      n_err++;
      $display("FAIL reach_wait: got busy=%b queued=%0d want 1 3", div_busy, iss_q.size());
    end
    mon_en = 1'b0;
    iss_q.delete();
    res_q.delete();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, in_ready, div_start, out_quo, out_rem, out_dbz} !==
        {1'b0, 1'b1, 1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got v=%b rdy=%b st=%b q=%h r=%h dbz=%b want 0 1 0 00 00 0",
               out_valid, in_ready, div_start, out_quo, out_rem, out_dbz);
    end
    step();
    step();
    rst = 1'b0;
    d0 = n_mdone;
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if ({out_valid, in_ready, div_start, out_quo, out_rem, out_dbz} !==
          {1'b0, 1'b1, 1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0}) begin
        n_err++;
        $display("FAIL post_reset%0d: got v=%b rdy=%b st=%b q=%h r=%h dbz=%b want 0 1 0 00 00 0",
                 i, out_valid, in_ready, div_start, out_quo, out_rem, out_dbz);
      end
      step();
    end
    n_vec++;
    if (n_mdone - d0 < 1) begin
      n_err++;
      $display("FAIL late_done_seen: got %0d late completions want at least 1", n_mdone - d0);
    end
    lat_fixed = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbz();
    test_hold();
    test_back_to_back();
    test_random();
    test_spurious();
    test_reset_wait();
    offer(8'd50, 8'd7);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
